rca_share_arb: RTL and testbench

- Time-shares one three-operand ripple-carry adder datapath (a+b+c) between NREQ independent requesters.
- Each requester offers an operand triple with a valid/ready handshake.
- A round-robin arbiter picks one requester, the block sequences the add, and returns the sum tagged with the requester ID over a valid/ready result channel.
- Sits between operand producers and the single shared adder, so the adder is never instantiated per requester.

---
 rtl/rca_share_pkg.sv | 15 +
 rtl/rca_rr_arbiter.sv | 38 +++
 rtl/rca_share_arb.sv | 106 ++++++++++
 tb/tb_rca_share_arb.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rca_share_pkg.sv
// Shared types and helpers for the time-shared three-operand adder.
package rca_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  // a+b+c of three W-bit operands fits in W+2 bits; the result port carries one spare bit.
  function automatic int sumWidth(input int w);
    return w + 3;
  endfunction

endpackage

// File: rtl/rca_rr_arbiter.sv
// Combinational round-robin arbiter: rotate the requests so the pointer sits at
// bit 0, take the lowest set bit, then rotate the winner back to an absolute index.
module rca_rr_arbiter
  import rca_share_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  logic [NREQ-1:0] rotated;
  logic [IDW-1:0]  offset;
  logic [IDW:0]    idxWide;

  always_comb begin
    rotated = NREQ'({req_i, req_i} >> ptr_i);
    offset  = '0;
    // Scanning downwards lets the lowest set bit win without an early exit.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        offset = IDW'(k);
      end
    end
    idxWide = {1'b0, ptr_i} + {1'b0, offset};
    if (idxWide >= (IDW+1)'(NREQ)) begin
      idxWide = idxWide - (IDW+1)'(NREQ);
    end
    any_o   = |req_i;
    idx_o   = idxWide[IDW-1:0];
    grant_o = any_o ? (NREQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/rca_share_arb.sv
// Time-shares one a+b+c adder between NREQ requesters: IDLE accepts one triple,
// CALC adds it, RESP holds the ID-tagged sum until the consumer takes it.
module rca_share_arb
  import rca_share_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int W    = 8,
  localparam int IDW  = $clog2(NREQ),
  localparam int SW   = sumWidth(W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*W-1:0] req_c,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [SW-1:0]     res_sum,
  output logic [IDW-1:0]    res_id
);

  state_e          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  id_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    c_q;
  logic [SW-1:0]   res_sum_q;
  logic [IDW-1:0]  res_id_q;
  logic            res_valid_q;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grantIdx;
  logic            anyReq;
  logic [W-1:0]    selA;
  logic [W-1:0]    selB;
  logic [W-1:0]    selC;
  logic [W:0]      sumAb_d;
  logic [W+1:0]    sum_d;

  rca_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (grantIdx),
    .any_o   (anyReq)
  );

  assign req_ready = (state_q == IDLE && anyReq) ? grant : '0;

  always_comb begin
    selA    = req_a[grantIdx*W +: W];
    selB    = req_b[grantIdx*W +: W];
    selC    = req_c[grantIdx*W +: W];
    sumAb_d = {1'b0, a_q} + {1'b0, b_q};
    sum_d   = {1'b0, sumAb_d} + {2'b00, c_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      res_sum_q   <= '0;
      res_id_q    <= '0;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (anyReq) begin
            a_q     <= selA;
            b_q     <= selB;
            c_q     <= selC;
            id_q    <= grantIdx;
            state_q <= CALC;
          end
        end
        CALC: begin
          res_sum_q   <= SW'(sum_d);
          res_id_q    <= id_q;
          res_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          // The requester just served becomes lowest priority for the next round.
          if (res_ready) begin
            res_valid_q <= 1'b0;
            ptr_q       <= (res_id_q == IDW'(NREQ - 1)) ? '0 : res_id_q + 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_rca_share_arb.sv
// Self-checking bench for rca_share_arb: directed scenarios plus random traffic,
// all scored against a transaction-level model of arbitration and latency.
module tb_rca_share_arb;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   reqValid = '0;
  logic [NREQ-1:0]   reqReady;
  logic [NREQ*W-1:0] reqA = '0;
  logic [NREQ*W-1:0] reqB = '0;
  logic [NREQ*W-1:0] reqC = '0;
  logic              resValid;
  logic              resReady = 1'b0;
  logic [W+2:0]      resSum;
  logic [IDW-1:0]    resId;

  int errors = 0;
  int checks = 0;

  int mPtr = 0;
  bit mBusy = 1'b0;
  int mAcceptCycle = 0;
  int expSum = 0;
  int expId = 0;
  int cycle = 0;

  logic [NREQ-1:0]   readySample = '0;
  logic [NREQ-1:0]   prevValid = '0;
  logic [NREQ-1:0]   prevReady = '0;
  logic [NREQ*W-1:0] prevA = '0;
  logic [NREQ*W-1:0] prevB = '0;
  logic [NREQ*W-1:0] prevC = '0;
  bit                prevReset = 1'b1;
  bit                resFired = 1'b0;
  logic [W+2:0]      sampledSum = '0;
  logic [IDW-1:0]    sampledId = '0;
  bit                autoDrop = 1'b0;

  rca_share_arb #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (reqValid),
    .req_ready (reqReady),
    .req_a     (reqA),
    .req_b     (reqB),
    .req_c     (reqC),
    .res_valid (resValid),
    .res_ready (resReady),
    .res_sum   (resSum),
    .res_id    (resId)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  // One clock: score outputs at the falling edge, advance the model, return just after the rising edge.
  task automatic tick();
    int grantIdx;
    logic [NREQ-1:0] expReady;
    bit expValid;
    @(negedge clk);
    cycle++;
    for (int i = 0; i < NREQ; i++) begin
      if (!prevReset && prevValid[i] && !prevReady[i]) begin
        assert (reqValid[i] && reqA[i*W +: W] == prevA[i*W +: W] &&
                reqB[i*W +: W] == prevB[i*W +: W] && reqC[i*W +: W] == prevC[i*W +: W])
          else $error("[TB] requester %0d altered a pending request", i);
      end
    end
    grantIdx = -1;
    if (!mBusy) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (mPtr + k) % NREQ;
        if (grantIdx < 0 && reqValid[idx]) grantIdx = idx;
      end
    end
    expReady = '0;
    if (grantIdx >= 0) expReady[grantIdx] = 1'b1;
    checkOutput("req_ready", 32'(reqReady), 32'(expReady));
    expValid = mBusy && (cycle >= mAcceptCycle + 2);
    checkOutput("res_valid", 32'(resValid), 32'(expValid));
    if (expValid) begin
      checkOutput("res_sum", 32'(resSum), expSum);
      checkOutput("res_id", 32'(resId), expId);
    end
    readySample = reqReady;
    resFired    = resValid && resReady && !reset;
    sampledSum  = resSum;
    sampledId   = resId;
    prevValid   = reqValid;
    prevReady   = reqReady;
    prevA       = reqA;
    prevB       = reqB;
    prevC       = reqC;
    prevReset   = reset;
    if (reset) begin
      mBusy = 1'b0;
      mPtr  = 0;
    end else if (expValid && resReady) begin
      mBusy = 1'b0;
      mPtr  = (expId + 1) % NREQ;
    end else if (grantIdx >= 0) begin
      mBusy        = 1'b1;
      mAcceptCycle = cycle;
      expSum       = int'(reqA[grantIdx*W +: W]) + int'(reqB[grantIdx*W +: W]) + int'(reqC[grantIdx*W +: W]);
      expId        = grantIdx;
    end
    @(posedge clk);
    #1;
    if (autoDrop) reqValid = reqValid & ~readySample;
  endtask

  task automatic resetDut();
    reset = 1'b1;
    tick();
    reqValid = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic setTriple(input int idx, input int a, input int b, input int c);
    reqA[idx*W +: W] = W'(a);
    reqB[idx*W +: W] = W'(b);
    reqC[idx*W +: W] = W'(c);
  endtask

  // Offer one triple from a single requester and withdraw it once accepted.
  task automatic applyStimulus(input int idx, input int a, input int b, input int c);
    setTriple(idx, a, b, c);
    reqValid[idx] = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (readySample[idx]) break;
    end
    checkOutput("accepted", 32'(readySample[idx]), 1);
    reqValid[idx] = 1'b0;
  endtask

  task automatic waitResult(output int gotSum, output int gotId, output int waited);
    gotSum = -1;
    gotId  = -1;
    waited = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (resFired) begin
        waited = n;
        gotSum = int'(sampledSum);
        gotId  = int'(sampledId);
        break;
      end
    end
    checkOutput("result_seen", 32'(resFired), 1);
  endtask

  initial begin
    int s;
    int id;
    int lat;

    tick();
    tick();
    reset = 1'b0;
    checkOutput("rst_res_valid", 32'(resValid), 0);
    checkOutput("rst_res_sum", 32'(resSum), 0);
    checkOutput("rst_res_id", 32'(resId), 0);
    checkOutput("rst_req_ready", 32'(reqReady), 0);

    // Single request and its two-cycle latency.
    resReady = 1'b1;
    applyStimulus(2, 200, 100, 50);
    waitResult(s, id, lat);
    checkOutput("single_latency", lat, 2);
    checkOutput("single_sum", s, 350);
    checkOutput("single_id", id, 2);

    // Largest operands.
    applyStimulus(0, 255, 255, 255);
    waitResult(s, id, lat);
    checkOutput("max_sum", s, 765);
    checkOutput("max_bit10", 32'(sampledSum[W+2]), 0);

    // Everyone requesting continuously from a fresh pointer.
    resetDut();
    for (int i = 0; i < NREQ; i++) setTriple(i, 10*i + 1, i + 2, 3*i);
    reqValid = '1;
    for (int r = 0; r < 6; r++) begin
      waitResult(s, id, lat);
      checkOutput("rr_id", id, r % NREQ);
      checkOutput("rr_sum", s, 14*(r % NREQ) + 3);
    end
    resetDut();

    // Back-pressure with a second request queued behind the held result.
    resReady = 1'b0;
    applyStimulus(1, 7, 9, 11);
    setTriple(1, 20, 21, 22);
    reqValid[1] = 1'b1;
    autoDrop = 1'b1;
    for (int n = 0; n < 10 && !resValid; n++) tick();
    checkOutput("bp_valid", 32'(resValid), 1);
    for (int n = 0; n < 10; n++) begin
      tick();
      checkOutput("bp_hold_sum", 32'(resSum), 27);
      checkOutput("bp_hold_id", 32'(resId), 1);
      checkOutput("bp_no_ready", 32'(reqReady), 0);
    end
    resReady = 1'b1;
    tick();
    checkOutput("bp_drop", 32'(resValid), 0);
    waitResult(s, id, lat);
    checkOutput("bp_next_sum", s, 63);
    autoDrop = 1'b0;

    // Reset while requester 1 is in the adder.
    applyStimulus(1, 5, 6, 7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("mid_valid", 32'(resValid), 0);
    setTriple(1, 4, 4, 4);
    setTriple(3, 9, 9, 9);
    reqValid = 4'b1010;
    autoDrop = 1'b1;
    #1;
    checkOutput("mid_grant", 32'(reqReady), 32'(4'b0010));
    waitResult(s, id, lat);
    checkOutput("mid_first_id", id, 1);
    checkOutput("mid_first_sum", s, 12);
    waitResult(s, id, lat);
    checkOutput("mid_second_id", id, 3);
    checkOutput("mid_second_sum", s, 27);

    // Sparse requests across the pointer wrap.
    resetDut();
    setTriple(3, 1, 2, 3);
    reqValid[3] = 1'b1;
    waitResult(s, id, lat);
    checkOutput("wrap_id3", id, 3);
    checkOutput("wrap_sum3", s, 6);
    setTriple(0, 0, 0, 0);
    reqValid[0] = 1'b1;
    waitResult(s, id, lat);
    checkOutput("wrap_id0", id, 0);
    checkOutput("wrap_sum0", s, 0);
    autoDrop = 1'b0;

    // Random traffic, back-pressure and occasional resets.
    resetDut();
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!reqValid[i] && $urandom_range(0, 2) == 0) begin
          setTriple(i, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
          reqValid[i] = 1'b1;
        end
      end
      resReady = ($urandom_range(0, 3) != 0);
      reset    = ($urandom_range(0, 99) == 0);
      tick();
      reqValid = reqValid & ~readySample;
    end
    reset    = 1'b0;
    resReady = 1'b1;
    for (int n = 0; n < 8; n++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
